// File: rtl/addr_trans_utlb.sv
// Registered virtual-to-physical translation with a small fully associative micro-TLB
// in front of the main TLB; mapped misses take a one-cycle main-TLB walk.
module addr_trans_utlb #(
  parameter int ENTRIES = 4,
  parameter bit TLB     = 1'b1,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_vaddr,
  input  logic              req_store,
  input  logic [ASID_W-1:0] asid,
  input  logic              flush,
  output logic              resp_valid,
  output logic [31:0]       resp_paddr,
  output logic              resp_excp_refill,
  output logic              resp_excp_invalid,
  output logic              resp_excp_mod,
  output logic              tlb_req,
  output logic [18:0]       tlb_vpn2,
  output logic              tlb_odd_page,
  output logic [ASID_W-1:0] tlb_asid,
  input  logic              tlb_found,
  input  logic              tlb_v,
  input  logic              tlb_d,
  input  logic              tlb_g,
  input  logic [19:0]       tlb_pfn
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ENTRIES - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WALK = 1'b1;

  logic [0:0]        state;
  logic [31:0]       walk_vaddr;
  logic              walk_store;
  logic [PTR_W-1:0]  rr_ptr;

  logic [ENTRIES-1:0] ent_valid;
  logic [18:0]        ent_vpn2 [ENTRIES];
  logic               ent_odd  [ENTRIES];
  logic [ASID_W-1:0]  ent_asid [ENTRIES];
  logic               ent_g    [ENTRIES];
  logic [19:0]        ent_pfn  [ENTRIES];
  logic               ent_d    [ENTRIES];

  logic        hit;
  logic [19:0] hit_pfn;
  logic        hit_d;
  logic        unmapped;
  logic        mapped_lookup;
  logic        accept;
  logic        direct;
  logic        do_fill;

  // Entries never duplicate, so at most one of these matches.
  always_comb begin
    hit     = 1'b0;
    hit_pfn = '0;
    hit_d   = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_valid[i] && ent_vpn2[i] == req_vaddr[31:13] && ent_odd[i] == req_vaddr[12] &&
          (ent_g[i] || ent_asid[i] == asid)) begin
        hit     = 1'b1;
        hit_pfn = ent_pfn[i];
        hit_d   = ent_d[i];
      end
    end
  end

  assign unmapped      = (req_vaddr[31:30] == 2'b10);
  assign mapped_lookup = !unmapped && (TLB != 1'b0);
  assign req_ready     = (state == S_IDLE);
  assign accept        = req_valid && req_ready;
  // A flush in the accept cycle forces a walk even when an entry matches.
  assign direct        = !mapped_lookup || (hit && !flush);
  assign do_fill       = (state == S_WALK) && tlb_found && tlb_v && !flush;

  assign tlb_req      = (state == S_WALK);
  assign tlb_vpn2     = tlb_req ? walk_vaddr[31:13] : '0;
  assign tlb_odd_page = tlb_req ? walk_vaddr[12] : 1'b0;
  assign tlb_asid     = tlb_req ? asid : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      walk_vaddr        <= '0;
      walk_store        <= 1'b0;
      resp_valid        <= 1'b0;
      resp_paddr        <= '0;
      resp_excp_refill  <= 1'b0;
      resp_excp_invalid <= 1'b0;
      resp_excp_mod     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (direct) begin
              resp_valid        <= 1'b1;
              resp_excp_refill  <= 1'b0;
              resp_excp_invalid <= 1'b0;
              resp_excp_mod     <= mapped_lookup && req_store && !hit_d;
              if (unmapped)
                resp_paddr <= req_vaddr & 32'h1FFF_FFFF;
              else if (TLB == 1'b0)
                resp_paddr <= req_vaddr;
              else
                resp_paddr <= {hit_pfn, req_vaddr[11:0]};
            end else begin
              walk_vaddr <= req_vaddr;
              walk_store <= req_store;
              state      <= S_WALK;
            end
          end
        end
        default: begin
          resp_valid        <= 1'b1;
          resp_paddr        <= tlb_found ? {tlb_pfn, walk_vaddr[11:0]} : 32'h0;
          resp_excp_refill  <= !tlb_found;
          resp_excp_invalid <= tlb_found && !tlb_v;
          resp_excp_mod     <= tlb_found && tlb_v && walk_store && !tlb_d;
          state             <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      ent_valid <= '0;
      rr_ptr    <= '0;
    end else if (do_fill) begin
      ent_valid[rr_ptr] <= 1'b1;
      rr_ptr            <= (rr_ptr == LAST_PTR) ? '0 : rr_ptr + 1'b1;
    end
  end

  // Entry payload needs no reset; it is qualified by ent_valid.
  always_ff @(posedge clk) begin
    if (do_fill) begin
      ent_vpn2[rr_ptr] <= walk_vaddr[31:13];
      ent_odd[rr_ptr]  <= walk_vaddr[12];
      ent_asid[rr_ptr] <= asid;
      ent_g[rr_ptr]    <= tlb_g;
      ent_pfn[rr_ptr]  <= tlb_pfn;
      ent_d[rr_ptr]    <= tlb_d;
    end
  end

endmodule

// File: tb/tb_addr_trans_utlb.sv
// Scoreboard bench for addr_trans_utlb: expected responses and main-TLB probes are queued
// when a request is driven and checked when the DUT produces them.
module tb_addr_trans_utlb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_store;
  logic [7:0]  asid;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_excp_refill;
  logic        resp_excp_invalid;
  logic        resp_excp_mod;
  logic        tlb_req;
  logic [18:0] tlb_vpn2;
  logic        tlb_odd_page;
  logic [7:0]  tlb_asid;
  logic        tlb_found;
  logic        tlb_v;
  logic        tlb_d;
  logic        tlb_g;
  logic [19:0] tlb_pfn;

  typedef struct {
    logic [31:0] paddr;
    logic        refill;
    logic        inv;
    logic        mod;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [18:0] vpn2;
    logic        odd;
    logic [7:0]  asid;
  } walk_t;

  resp_t exp_q[$];
  walk_t walk_q[$];
  resp_t mon_r;
  walk_t mon_w;
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  addr_trans_utlb #(.ENTRIES(4), .TLB(1'b1), .ASID_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_store(req_store), .asid(asid), .flush(flush),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr),
    .resp_excp_refill(resp_excp_refill), .resp_excp_invalid(resp_excp_invalid),
    .resp_excp_mod(resp_excp_mod),
    .tlb_req(tlb_req), .tlb_vpn2(tlb_vpn2), .tlb_odd_page(tlb_odd_page), .tlb_asid(tlb_asid),
    .tlb_found(tlb_found), .tlb_v(tlb_v), .tlb_d(tlb_d), .tlb_g(tlb_g), .tlb_pfn(tlb_pfn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response and probe monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_resp", resp_valid, 32'd0);
      end else begin
        mon_r = exp_q.pop_front();
        checkOutput("resp_paddr", resp_paddr, mon_r.paddr);
        checkOutput("resp_refill", resp_excp_refill, mon_r.refill);
        checkOutput("resp_invalid", resp_excp_invalid, mon_r.inv);
        checkOutput("resp_mod", resp_excp_mod, mon_r.mod);
        checkOutput("resp_cycle", cyc, mon_r.cyc);
      end
    end
    if (!reset && tlb_req) begin
      if (walk_q.size() == 0) begin
        checkOutput("unexpected_tlb_req", tlb_req, 32'd0);
      end else begin
        mon_w = walk_q.pop_front();
        checkOutput("tlb_vpn2", tlb_vpn2, mon_w.vpn2);
        checkOutput("tlb_odd_page", tlb_odd_page, mon_w.odd);
        checkOutput("tlb_asid", tlb_asid, mon_w.asid);
      end
    end
  end

  // flush_mode: 0 none, 1 flush in the accept cycle, 2 flush in the walk cycle.
  task automatic applyStimulus(input logic [31:0] vaddr, input logic store, input logic walk,
                               input logic [31:0] exp_paddr, input logic exp_refill,
                               input logic exp_inv, input logic exp_mod, input int flush_mode);
    resp_t r;
    walk_t w;
    @(negedge clk);
    checkOutput("req_ready", req_ready, 32'd1);
    req_valid = 1'b1;
    req_vaddr = vaddr;
    req_store = store;
    if (flush_mode == 1) flush = 1'b1;
    r.paddr  = exp_paddr;
    r.refill = exp_refill;
    r.inv    = exp_inv;
    r.mod    = exp_mod;
    r.cyc    = cyc + (walk ? 2 : 1);
    exp_q.push_back(r);
    if (walk) begin
      w.vpn2 = vaddr[31:13];
      w.odd  = vaddr[12];
      w.asid = asid;
      walk_q.push_back(w);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    if (walk) begin
      @(negedge clk);
      checkOutput("walk_req_ready", req_ready, 32'd0);
      if (flush_mode == 2) flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
  endtask

  task automatic walkReq(input logic [31:0] vaddr, input logic store, input logic found,
                         input logic v, input logic d, input logic g, input logic [19:0] pfn,
                         input int flush_mode);
    tlb_found = found;
    tlb_v     = v;
    tlb_d     = d;
    tlb_g     = g;
    tlb_pfn   = pfn;
    applyStimulus(vaddr, store, 1'b1, found ? {pfn, vaddr[11:0]} : 32'h0,
                  !found, found && !v, found && v && store && !d, flush_mode);
  endtask

  task automatic hitReq(input logic [31:0] vaddr, input logic store, input logic [19:0] pfn,
                        input logic d);
    applyStimulus(vaddr, store, 1'b0, {pfn, vaddr[11:0]}, 1'b0, 1'b0, store && !d, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_vaddr = '0;
    req_store = 1'b0;
    asid      = 8'h05;
    flush     = 1'b0;
    tlb_found = 1'b0;
    tlb_v     = 1'b0;
    tlb_d     = 1'b0;
    tlb_g     = 1'b0;
    tlb_pfn   = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_resp_valid", resp_valid, 32'd0);
    checkOutput("rst_resp_paddr", resp_paddr, 32'd0);
    checkOutput("rst_flags", {29'd0, resp_excp_refill, resp_excp_invalid, resp_excp_mod}, 32'd0);
    checkOutput("rst_tlb_req", tlb_req, 32'd0);
    checkOutput("rst_tlb_probe", {12'd0, tlb_vpn2, tlb_odd_page}, 32'd0);
    checkOutput("rst_tlb_asid", tlb_asid, 32'd0);
    checkOutput("rst_req_ready", req_ready, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Unmapped back-to-back
    applyStimulus(32'h8000_1234, 1'b0, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(32'hBFC0_0000, 1'b0, 1'b0, 32'h1FC0_0000, 1'b0, 1'b0, 1'b0, 0);

    // Miss then hit
    walkReq(32'h0040_3ABC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h12345, 0);
    hitReq(32'h0040_3ABC, 1'b0, 20'h12345, 1'b1);

    // Other ASID misses; refill twice shows nothing was cached
    asid = 8'h06;
    walkReq(32'h0040_3ABC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 0);
    walkReq(32'h0040_3ABC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 0);
    asid = 8'h05;

    // Invalid page, then store to clean page
    walkReq(32'h0050_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'h11111, 0);
    walkReq(32'h0050_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'h11111, 0);
    walkReq(32'h0060_1004, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h22222, 0);
    hitReq(32'h0060_1004, 1'b1, 20'h22222, 1'b0);
    hitReq(32'h0060_1004, 1'b0, 20'h22222, 1'b0);

    // Global entry hits under any ASID
    walkReq(32'h0070_2008, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 20'h33333, 0);
    asid = 8'h9A;
    hitReq(32'h0070_2008, 1'b0, 20'h33333, 1'b1);
    asid = 8'h05;

    // Standalone flush empties the micro-TLB and rewinds the pointer
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;

    // Round-robin replacement: A..E, E evicts A, refilled A evicts B
    walkReq(32'h0040_3ABC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0A001, 0);
    walkReq(32'h0100_0010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0A002, 0);
    walkReq(32'h0100_2020, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0A003, 0);
    walkReq(32'h0100_4030, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0A004, 0);
    walkReq(32'h0100_6040, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0A005, 0);
    hitReq(32'h0100_0010, 1'b0, 20'h0A002, 1'b1);
    hitReq(32'h0100_2020, 1'b0, 20'h0A003, 1'b1);
    hitReq(32'h0100_4030, 1'b0, 20'h0A004, 1'b1);
    hitReq(32'h0100_6040, 1'b0, 20'h0A005, 1'b1);
    walkReq(32'h0040_3ABC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0A011, 0);
    hitReq(32'h0040_3ABC, 1'b0, 20'h0A011, 1'b1);
    hitReq(32'h0100_2020, 1'b0, 20'h0A003, 1'b1);
    hitReq(32'h0100_6040, 1'b0, 20'h0A005, 1'b1);
    walkReq(32'h0100_0010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0A012, 0);

    // Flush during a walk delivers the result but drops the fill
    walkReq(32'h0200_0100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0B000, 2);
    walkReq(32'h0200_0100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0B001, 0);
    hitReq(32'h0200_0100, 1'b0, 20'h0B001, 1'b1);
    // Flush in the accept cycle forces a miss on a cached page
    walkReq(32'h0200_0100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0B002, 1);
    hitReq(32'h0200_0100, 1'b0, 20'h0B002, 1'b1);

    // Reset in the walk cycle aborts without a response
    @(negedge clk);
    req_valid = 1'b1;
    req_vaddr = 32'h0300_0000;
    req_store = 1'b0;
    @(posedge clk);
    #2;
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("midwalk_req_ready", req_ready, 32'd1);
    checkOutput("midwalk_tlb_req", tlb_req, 32'd0);
    checkOutput("midwalk_resp_valid", resp_valid, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    walkReq(32'h0200_0100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0C000, 0);
    walkReq(32'h0300_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0C001, 0);

    repeat (3) @(negedge clk);
    checkOutput("pending_resp", exp_q.size(), 32'd0);
    checkOutput("pending_walk", walk_q.size(), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
